// File: rtl/sprite_scan.sv
// Sprite list reader: walks the x-sorted sprite index list once per scanline and
// issues one fetch request per active sprite, paced by a valid/ready handshake.
module sprite_scan #(
    parameter int SPRITES  = 128,
    parameter int IDX_BITS = 7,
    parameter int X_BITS   = 10,
    parameter int LEAD     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IDX_BITS*SPRITES-1:0]  idx,
    input  logic [X_BITS*SPRITES-1:0]    x,
    input  logic [X_BITS-1:0]            hcount,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [IDX_BITS-1:0]          req_idx,
    output logic [X_BITS-1:0]            req_x,
    output logic                         req_late,
    output logic [IDX_BITS:0]            count,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [X_BITS:0]   LEAD_EXT  = (X_BITS+1)'(LEAD);
    localparam logic [IDX_BITS-1:0] LAST_PTR = IDX_BITS'(SPRITES - 1);

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   ptr_q, ptr_d;
    logic [IDX_BITS:0]     count_q, count_d;
    logic                  req_valid_q, req_valid_d;
    logic [IDX_BITS-1:0]   req_idx_q, req_idx_d;
    logic [X_BITS-1:0]     req_x_q, req_x_d;
    logic                  req_late_q, req_late_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [IDX_BITS-1:0]   idx_arr [SPRITES];
    logic [X_BITS-1:0]     x_arr   [SPRITES];

    for (genvar k = 0; k < SPRITES; k++) begin : g_unpack
        assign idx_arr[k] = idx[IDX_BITS*k +: IDX_BITS];
        assign x_arr[k]   = x[X_BITS*k +: X_BITS];
    end

    logic [IDX_BITS-1:0]   entry;
    logic [X_BITS-1:0]     entry_x;
    logic [X_BITS:0]       reach;
    logic                  disabled;
    logic                  eligible;
    logic                  slot_free;
    logic                  handshake;
    logic                  last_entry;

    assign entry      = idx_arr[ptr_q];
    assign entry_x    = x_arr[entry];
    // Widened by one bit so hcount + LEAD near the line end cannot wrap.
    assign reach      = {1'b0, hcount} + LEAD_EXT;
    assign disabled   = &entry_x;
    assign eligible   = ({1'b0, entry_x} <= reach);
    assign slot_free  = !req_valid_q || req_ready;
    assign handshake  = req_valid_q && req_ready;
    assign last_entry = (ptr_q == LAST_PTR);

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        req_valid_d = req_valid_q;
        req_idx_d   = req_idx_q;
        req_x_d     = req_x_q;
        req_late_d  = req_late_q;

        if (handshake) begin
            count_d     = count_q + 1'b1;
            req_valid_d = 1'b0;
        end

        if (start) begin
            // Fresh walk from any state; a pending request is abandoned.
            state_d     = S_SCAN;
            ptr_d       = '0;
            count_d     = '0;
            req_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_SCAN: begin
                    if (disabled) begin
                        // Sorted list: a disabled entry means nothing later is active.
                        state_d = S_DRAIN;
                    end else if (slot_free && eligible) begin
                        req_valid_d = 1'b1;
                        req_idx_d   = entry;
                        req_x_d     = entry_x;
                        req_late_d  = (entry_x < hcount);
                        ptr_d       = ptr_q + 1'b1;
                        if (last_entry) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!req_valid_q || req_ready) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            req_valid_q <= 1'b0;
            req_idx_q   <= '0;
            req_x_q     <= '0;
            req_late_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            req_valid_q <= req_valid_d;
            req_idx_q   <= req_idx_d;
            req_x_q     <= req_x_d;
            req_late_q  <= req_late_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_idx   = req_idx_q;
    assign req_x     = req_x_q;
    assign req_late  = req_late_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_scan.sv
// Directed scoreboard bench for sprite_scan with a four-entry sprite list.
module tb_sprite_scan;

    localparam int SPRITES  = 4;
    localparam int IDX_BITS = 2;
    localparam int X_BITS   = 10;
    localparam int LEAD     = 16;

    typedef struct packed {
        logic [IDX_BITS-1:0] idx;
        logic [X_BITS-1:0]   x;
        logic                late;
    } req_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        start;
    logic [IDX_BITS*SPRITES-1:0] idx;
    logic [X_BITS*SPRITES-1:0]   x;
    logic [X_BITS-1:0]           hcount;
    logic                        req_valid;
    logic                        req_ready;
    logic [IDX_BITS-1:0]         req_idx;
    logic [X_BITS-1:0]           req_x;
    logic                        req_late;
    logic [IDX_BITS:0]           count;
    logic                        busy;
    logic                        done;

    int   checks = 0;
    int   errors = 0;
    bit   ramp   = 1'b0;
    req_t sb[$];

    int   idx_list [SPRITES] = '{1, 3, 0, 2};
    int   x_list   [SPRITES] = '{100, 40, 1023, 70};

    sprite_scan #(
        .SPRITES  (SPRITES),
        .IDX_BITS (IDX_BITS),
        .X_BITS   (X_BITS),
        .LEAD     (LEAD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .idx       (idx),
        .x         (x),
        .hcount    (hcount),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_x     (req_x),
        .req_late  (req_late),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_list();
        for (int k = 0; k < SPRITES; k++) begin
            idx[IDX_BITS*k +: IDX_BITS] = IDX_BITS'(idx_list[k]);
            x[X_BITS*k +: X_BITS]       = X_BITS'(x_list[k]);
        end
    endtask

    // Expected request stream: sorted order, stopping at the first disabled sprite.
    task automatic push_list(input logic late);
        req_t r;
        for (int k = 0; k < SPRITES; k++) begin
            if (x_list[idx_list[k]] == 1023) break;
            r.idx  = IDX_BITS'(idx_list[k]);
            r.x    = X_BITS'(x_list[idx_list[k]]);
            r.late = late;
            sb.push_back(r);
        end
    endtask

    // One clock: score any handshake about to happen, then advance past the edge.
    task automatic step();
        req_t e;
        if (req_valid && req_ready) begin
            check("unexpected_req", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("req_idx", req_idx, e.idx);
                check("req_x", req_x, e.x);
                check("req_late", req_late, e.late);
                if (ramp) check("ramp_timing", hcount, e.x - LEAD + 1);
            end
        end
        @(posedge clk);
        #1;
        if (ramp) hcount = hcount + 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        req_ready = 1'b1;
        hcount    = '0;
        apply_list();
        #12;
        check("rst_valid", req_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        reset = 1'b0;
        step();
        step();
        check("idle_busy", busy, 0);

        // Beam ramp: each request appears just as the beam comes within LEAD.
        hcount = '0;
        ramp   = 1'b1;
        push_list(1'b0);
        pulse_start();
        run_to_done("ramp_done", 300);
        check("ramp_count", count, 3);
        check("ramp_sb_empty", sb.size(), 0);
        check("ramp_busy", busy, 0);
        ramp = 1'b0;

        // Beam already past every sprite: back-to-back late requests.
        hcount = 10'd200;
        push_list(1'b1);
        pulse_start();
        check("b2b_first_latency", req_valid, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("b2b_valid", req_valid, 1);
            step();
        end
        check("b2b_drain_valid", req_valid, 0);
        check("b2b_not_done", done, 0);
        step();
        check("b2b_done", done, 1);
        check("b2b_count", count, 3);
        check("b2b_sb_empty", sb.size(), 0);

        // Every sprite disabled: no requests, done three edges after start.
        for (int k = 0; k < SPRITES; k++) x[X_BITS*k +: X_BITS] = '1;
        pulse_start();
        check("empty_busy", busy, 1);
        check("empty_done_early1", done, 0);
        step();
        check("empty_done_early2", done, 0);
        check("empty_valid", req_valid, 0);
        step();
        check("empty_done", done, 1);
        check("empty_count", count, 0);
        apply_list();

        // Backpressure: the pending request holds steady until accepted.
        push_list(1'b1);
        req_ready = 1'b0;
        pulse_start();
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", req_valid, 1);
            check("hold_idx", req_idx, 1);
            check("hold_x", req_x, 40);
            step();
        end
        check("hold_count", count, 0);
        req_ready = 1'b1;
        step();
        check("hold_accept_count", count, 1);
        run_to_done("hold_done", 20);
        check("hold_final_count", count, 3);

        // Restart while the second request is pending.
        push_list(1'b1);
        pulse_start();
        step();
        step();
        check("abort_pending_idx", req_idx, 3);
        req_ready = 1'b0;
        start     = 1'b1;
        step();
        start     = 1'b0;
        req_ready = 1'b1;
        check("abort_valid", req_valid, 0);
        check("abort_count", count, 0);
        check("abort_busy", busy, 1);
        sb.delete();
        push_list(1'b1);
        step();
        check("abort_reemit_idx", req_idx, 1);
        check("abort_reemit_x", req_x, 40);
        run_to_done("abort_done", 20);
        check("abort_final_count", count, 3);

        // Asynchronous reset in the middle of a walk.
        push_list(1'b1);
        pulse_start();
        step();
        step();
        check("areset_pre_count", count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", req_valid, 0);
        check("areset_done", done, 0);
        check("areset_busy", busy, 0);
        check("areset_count", count, 0);
        #1;
        reset = 1'b0;
        sb.delete();
        step();
        step();
        step();
        check("areset_idle_busy", busy, 0);
        check("areset_idle_valid", req_valid, 0);
        check("areset_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
